// File: rtl/pwd_serial_tx_if.sv
// Host-side bundle for the serial password transmitter: request, BCD digits,
// the serial line and the status strobes, plus the FSM state for observation.
interface pwd_serial_tx_if;
   // Handshake: start is a level request sampled only while busy is low;
   // each sampled request yields exactly one done or one err pulse, never both,
   // and nothing is queued while busy.
   logic        start;
   logic [15:0] digits;
   logic        ser_out;
   logic        busy;
   logic        done;
   logic        err;
   logic [2:0]  state;

   modport master (
      output start, digits,
      input  ser_out, busy, done, err, state
   );

   modport slave (
      input  start, digits,
      output ser_out, busy, done, err, state
   );
endinterface

// File: rtl/pwd_serial_tx.sv
// Serializes a validated 4-digit BCD password as start, 16 data bits (MSB
// first), even parity and stop, each held CLKS_PER_BIT clocks.
module pwd_serial_tx #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic         clk,
   input  logic         rst,
   pwd_serial_tx_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [7:0] LAST_DIV = 8'(CLKS_PER_BIT - 1);

   logic [2:0]  r_state;
   logic [7:0]  r_div;
   logic [3:0]  r_idx;
   logic [15:0] r_shift;
   logic        r_parity;
   logic        r_done;
   logic        r_err;
   logic        w_valid;
   logic        w_bit_end;
   logic        w_ser;

   assign w_valid = (bus.digits[15:12] <= 4'd9) && (bus.digits[11:8] <= 4'd9) &&
                    (bus.digits[7:4]   <= 4'd9) && (bus.digits[3:0]  <= 4'd9);
   assign w_bit_end = (r_div == LAST_DIV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_div    <= 8'd0;
         r_idx    <= 4'd0;
         r_shift  <= 16'd0;
         r_parity <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_div <= 8'd0;
               if (bus.start) begin
                  if (w_valid) begin
                     r_shift  <= bus.digits;
                     r_parity <= ^bus.digits;
                     r_idx    <= 4'd15;
                     r_state  <= S_START;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_div   <= 8'd0;
                  r_idx   <= 4'd15;
                  r_state <= S_DATA;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_div <= 8'd0;
                  // Index stops at 0 instead of wrapping; the shift is irrelevant past bit 0.
                  if (r_idx == 4'd0) begin
                     r_state <= S_PARITY;
                  end else begin
                     r_shift <= {r_shift[14:0], 1'b0};
                     r_idx   <= r_idx - 4'd1;
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_div   <= 8'd0;
                  r_state <= S_STOP;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_div   <= 8'd0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            default: begin
               r_div   <= 8'd0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_ser = 1'b0;
      case (r_state)
         S_START:  w_ser = 1'b1;
         S_DATA:   w_ser = r_shift[15];
         S_PARITY: w_ser = r_parity;
         default:  w_ser = 1'b0;
      endcase
   end

   assign bus.ser_out = w_ser;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.state   = r_state;
endmodule

// File: tb/tb_pwd_serial_tx.sv
// Directed bench for pwd_serial_tx: a vector table on a 1-clock-per-bit
// instance plus hand sequences for stretched bits, back-to-back and reset.
module tb_pwd_serial_tx;
   localparam logic [2:0] ST_IDLE = 3'd0;

   typedef struct {
      logic [15:0] digits;
      logic        exp_err;
      logic [18:0] exp_frame;
   } vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   vec_t vecs[8];

   pwd_serial_tx_if a_if ();
   pwd_serial_tx_if b_if ();

   pwd_serial_tx #(.CLKS_PER_BIT(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
   pwd_serial_tx #(.CLKS_PER_BIT(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

   // {ser_out, busy, done, err}
   logic [3:0] outs_a;
   logic [3:0] outs_b;
   assign outs_a = {a_if.ser_out, a_if.busy, a_if.done, a_if.err};
   assign outs_b = {b_if.ser_out, b_if.busy, b_if.done, b_if.err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      a_if.digits = v.digits;
      a_if.start  = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      if (v.exp_err) begin
         check("err_pulse", outs_a, 4'b0001);
         @(negedge clk);
         check("err_clear", outs_a, 4'b0000);
         @(negedge clk);
         check("err_idle", outs_a, 4'b0000);
      end else begin
         for (int i = 0; i < 19; i++) begin
            check("frame_bit", outs_a, {v.exp_frame[18-i], 1'b1, 2'b00});
            @(negedge clk);
         end
         check("done_pulse", outs_a, 4'b0010);
         @(negedge clk);
         check("after_done", outs_a, 4'b0000);
      end
   endtask

   initial begin
      logic [18:0] f9999;
      logic [18:0] f0000;
      n_pass  = 0;
      n_total = 0;
      f9999 = 19'b1_1001100110011001_0_0;
      f0000 = 19'b1_0000000000000000_0_0;
      vecs[0] = '{16'h4475, 1'b0, 19'b1_0100010001110101_1_0};
      vecs[1] = '{16'h12A4, 1'b1, 19'd0};
      vecs[2] = '{16'h0000, 1'b0, 19'b1_0000000000000000_0_0};
      vecs[3] = '{16'h9999, 1'b0, 19'b1_1001100110011001_0_0};
      vecs[4] = '{16'h0009, 1'b0, 19'b1_0000000000001001_0_0};
      vecs[5] = '{16'hA000, 1'b1, 19'd0};
      vecs[6] = '{16'h1234, 1'b0, 19'b1_0001001000110100_1_0};
      vecs[7] = '{16'h000F, 1'b1, 19'd0};

      rst = 1'b1;
      a_if.start = 1'b0; a_if.digits = 16'h0000;
      b_if.start = 1'b0; b_if.digits = 16'h0000;

      // Reset then idle
      repeat (2) @(negedge clk);
      check("rst_outs_a", outs_a, 4'b0000);
      check("rst_state_a", a_if.state, ST_IDLE);
      check("rst_outs_b", outs_b, 4'b0000);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_a", outs_a, 4'b0000);
         check("idle_b", outs_b, 4'b0000);
      end

      // Vector table
      for (int k = 0; k < 8; k++) apply_vec(vecs[k]);

      // Stretched bits, digits changed mid-frame
      @(negedge clk);
      b_if.digits = 16'h9999;
      b_if.start  = 1'b1;
      @(negedge clk);
      b_if.start = 1'b0;
      for (int c = 0; c < 76; c++) begin
         if (c == 20) b_if.digits = 16'h0000;
         check("stretch_bit", outs_b, {f9999[18 - c/4], 1'b1, 2'b00});
         @(negedge clk);
      end
      check("stretch_done", outs_b, 4'b0010);
      @(negedge clk);
      check("stretch_after", outs_b, 4'b0000);

      // Back-to-back with start held high
      @(negedge clk);
      a_if.digits = 16'h0000;
      a_if.start  = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 19; i++) begin
         check("b2b_frame1", outs_a, {f0000[18-i], 1'b1, 2'b00});
         @(negedge clk);
      end
      check("b2b_gap_done", outs_a, 4'b0010);
      @(negedge clk);
      for (int i = 0; i < 19; i++) begin
         if (i == 2) a_if.start = 1'b0;
         check("b2b_frame2", outs_a, {f0000[18-i], 1'b1, 2'b00});
         @(negedge clk);
      end
      check("b2b_done2", outs_a, 4'b0010);
      @(negedge clk);
      check("b2b_no_queue", outs_a, 4'b0000);
      @(negedge clk);
      check("b2b_idle", outs_a, 4'b0000);

      // Invalid start held into the done cycle: err follows done
      @(negedge clk);
      a_if.digits = 16'h0000;
      a_if.start  = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      for (int i = 0; i < 19; i++) begin
         if (i == 5) begin
            a_if.digits = 16'hFFFF;
            a_if.start  = 1'b1;
         end
         check("busy_ignore", outs_a, {f0000[18-i], 1'b1, 2'b00});
         @(negedge clk);
      end
      check("done_no_err", outs_a, 4'b0010);
      @(negedge clk);
      a_if.start = 1'b0;
      check("err_after_done", outs_a, 4'b0001);
      @(negedge clk);
      check("err_after_idle", outs_a, 4'b0000);

      // Reset during DATA bit 7
      @(negedge clk);
      a_if.digits = 16'h4475;
      a_if.start  = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("pre_rst_bit", outs_a, {vecs[0].exp_frame[18-i], 1'b1, 2'b00});
         if (i < 9) @(negedge clk);
      end
      #1 rst = 1'b1;
      #1;
      check("rst_abort_outs", outs_a, 4'b0000);
      check("rst_abort_state", a_if.state, ST_IDLE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", outs_a, 4'b0000);
      end
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", outs_a, 4'b0000);
      apply_vec(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
